// File: rtl/pll_pfd.sv
// Clocked phase-frequency detector for the digital PLL.
// Both square-wave inputs are synchronized into clk, rising edges are
// extracted, and a three-state machine (idle / UP / DN) produces UP/DN
// pulses whose width in clk cycles equals the synchronized edge separation,
// capped by a timeout. The setting bus reports pulse activity and direction.
module pll_pfd #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PULSE   = 4096,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       link,
  input  logic       vco,
  output logic [1:0] setting,
  output logic       up,
  output logic       dn,
  output logic       upb,
  output logic       dnb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PULSE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DN   = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] link_sync_q;
  logic [SYNC_STAGES-1:0] vco_sync_q;
  logic                   link_dly_q;
  logic                   vco_dly_q;
  logic                   rise_l;
  logic                   rise_v;

  state_t                 state_q, state_d;
  logic                   dir_q, dir_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   timeout;

  // Synchronizer chains plus one edge-delay flop per input.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      link_sync_q <= '0;
      vco_sync_q  <= '0;
      link_dly_q  <= 1'b0;
      vco_dly_q   <= 1'b0;
    end else begin
      link_sync_q <= {link_sync_q[SYNC_STAGES-2:0], link};
      vco_sync_q  <= {vco_sync_q[SYNC_STAGES-2:0], vco};
      link_dly_q  <= link_sync_q[SYNC_STAGES-1];
      vco_dly_q   <= vco_sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_l  = link_sync_q[SYNC_STAGES-1] & ~link_dly_q;
  assign rise_v  = vco_sync_q[SYNC_STAGES-1] & ~vco_dly_q;
  assign timeout = (cnt_q == CNT_LAST);

  // Detector state, direction flag and pulse-length counter registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a pulse opens on a lone rise and closes on the
  // opposite input's rise or on timeout; repeated same-side rises are ignored.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (rise_l && !rise_v) begin
          state_d = S_UP;
          dir_d   = 1'b1;
        end else if (rise_v && !rise_l) begin
          state_d = S_DN;
          dir_d   = 1'b0;
        end
      end
      S_UP: begin
        if (rise_v || timeout) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DN: begin
        if (rise_l || timeout) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state only.
  assign up      = (state_q == S_UP);
  assign dn      = (state_q == S_DN);
  assign upb     = ~up;
  assign dnb     = ~dn;
  assign setting = {dir_q, up | dn};

endmodule

// File: tb/tb_pll_pfd.sv
// Self-checking bench for pll_pfd: directed scenarios plus random toggling,
// compared every cycle against an event-level reference model.
module tb_pll_pfd;

  localparam int S    = 2;
  localparam int MAXP = 4096;

  logic       clk;
  logic       nrst;
  logic       link;
  logic       vco;
  logic [1:0] setting;
  logic       up, dn, upb, dnb;

  int tests = 0;
  int fails = 0;

  // Reference model: sample history, open-pulse flag, polarity, start time.
  bit hl[$];
  bit hv[$];
  bit m_open;
  bit m_pol;
  bit m_dir;
  int m_t0;
  int n_edge = 0;

  int up_cnt, dn_cnt, s0_cnt;

  pll_pfd #(
    .SYNC_STAGES(S),
    .MAX_PULSE  (MAXP),
    .CNT_W      (16)
  ) dut (
    .clk    (clk),
    .nrst   (nrst),
    .link   (link),
    .vco    (vco),
    .setting(setting),
    .up     (up),
    .dn     (dn),
    .upb    (upb),
    .dnb    (dnb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b at edge %0d", tag, obs, exp, n_edge);
    end
  endtask

  task automatic hist_clear();
    hl.delete();
    hv.delete();
    for (int i = 0; i < S + 1; i++) begin
      hl.push_back(1'b0);
      hv.push_back(1'b0);
    end
  endtask

  task automatic model_edge();
    bit rl, rv, other;
    if (!nrst) begin
      m_open = 1'b0;
      m_dir  = 1'b0;
      hist_clear();
    end else begin
      rl = hl[hl.size()-S] & ~hl[hl.size()-S-1];
      rv = hv[hv.size()-S] & ~hv[hv.size()-S-1];
      if (!m_open) begin
        if (rl != rv) begin
          m_open = 1'b1;
          m_pol  = rl;
          m_dir  = rl;
          m_t0   = n_edge;
        end
      end else begin
        other = m_pol ? rv : rl;
        if (other || (n_edge - m_t0) >= MAXP) m_open = 1'b0;
      end
      hl.push_back(link);
      hv.push_back(vco);
      void'(hl.pop_front());
      void'(hv.pop_front());
    end
  endtask

  // One clock edge: advance the model, then check every output after the edge.
  task automatic cyc();
    @(posedge clk);
    n_edge++;
    model_edge();
    #1;
    chk("up",      {1'b0, up},  {1'b0, m_open && m_pol});
    chk("dn",      {1'b0, dn},  {1'b0, m_open && !m_pol});
    chk("upb",     {1'b0, upb}, {1'b0, !(m_open && m_pol)});
    chk("dnb",     {1'b0, dnb}, {1'b0, !(m_open && !m_pol)});
    chk("setting", setting,     {m_dir, m_open});
    up_cnt += int'(up);
    dn_cnt += int'(dn);
    s0_cnt += int'(setting[0]);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic clr_cnt();
    up_cnt = 0;
    dn_cnt = 0;
    s0_cnt = 0;
  endtask

  initial begin
    nrst = 1'b0;
    link = 1'b0;
    vco  = 1'b0;
    hist_clear();
    m_open = 1'b0;
    m_pol  = 1'b0;
    m_dir  = 1'b0;
    m_t0   = 0;
    clr_cnt();

    // Reset held with inputs toggling.
    for (int i = 0; i < 12; i++) begin
      link = 1'($urandom);
      vco  = 1'($urandom);
      cyc();
    end
    chk("reset_setting", setting, 2'b00);
    chk("reset_bars", {upb, dnb}, 2'b11);
    link = 1'b0;
    vco  = 1'b0;
    nrst = 1'b1;
    run(10);

    // Link leads vco by 100 cycles, with latency check.
    clr_cnt();
    link = 1'b1;
    cyc();
    cyc();
    chk("lat_before", {1'b0, up}, 2'b00);
    cyc();
    chk("lat_at", {1'b0, up}, 2'b01);
    chk("lead_setting", setting, 2'b11);
    run(97);
    vco = 1'b1;
    run(10);
    chk("lead_width", 2'(up_cnt == 100), 2'b01);
    chk("lead_no_dn", 2'(dn_cnt == 0), 2'b01);
    chk("lead_after", setting, 2'b10);
    link = 1'b0;
    vco  = 1'b0;
    run(10);

    // Vco leads link by 37 cycles.
    clr_cnt();
    vco = 1'b1;
    run(37);
    link = 1'b1;
    run(10);
    chk("vlead_width", 2'(dn_cnt == 37), 2'b01);
    chk("vlead_after", setting, 2'b00);
    link = 1'b0;
    vco  = 1'b0;
    run(10);

    // Coincident rises.
    clr_cnt();
    link = 1'b1;
    vco  = 1'b1;
    run(10);
    chk("coinc_s0", 2'(s0_cnt == 0), 2'b01);
    link = 1'b0;
    vco  = 1'b0;
    run(10);

    // Two link rises before one vco rise: a single 80-cycle up pulse.
    clr_cnt();
    link = 1'b1;
    run(20);
    link = 1'b0;
    run(10);
    link = 1'b1;
    run(50);
    vco = 1'b1;
    run(10);
    chk("freq_width", 2'(up_cnt == 80), 2'b01);
    link = 1'b0;
    vco  = 1'b0;
    run(10);

    // Timeout with vco held low, then vco opens a dn pulse.
    clr_cnt();
    link = 1'b1;
    run(4200);
    chk("timeout_width", 2'(up_cnt == MAXP), 2'b01);
    chk("timeout_setting", setting, 2'b10);
    clr_cnt();
    vco = 1'b1;
    run(5);
    chk("post_to_dn", {1'b0, dn}, 2'b01);
    link = 1'b0;
    run(5);
    link = 1'b1;
    run(10);
    chk("post_to_dn_width", 2'(dn_cnt == 10), 2'b01);
    link = 1'b0;
    vco  = 1'b0;
    run(10);

    // Reset mid-pulse; link still high afterwards re-arms a detection.
    link = 1'b1;
    run(20);
    nrst = 1'b0;
    cyc();
    chk("midrst_setting", setting, 2'b00);
    chk("midrst_updn", {up, dn}, 2'b00);
    nrst = 1'b1;
    cyc();
    cyc();
    chk("rearm_before", {1'b0, up}, 2'b00);
    cyc();
    chk("rearm_at", {1'b0, up}, 2'b01);
    vco = 1'b1;
    run(10);
    link = 1'b0;
    vco  = 1'b0;
    run(10);

    // Random toggling with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) link = ~link;
      if ($urandom_range(0, 22) == 0) vco = ~vco;
      if ($urandom_range(0, 60) == 0) begin
        link = ~link;
        vco  = ~vco;
      end
      nrst = ($urandom_range(0, 499) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
